// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared constants and glyph table for the 7-segment scan driver
package seg7_pkg;

    localparam int DIGIT_W = 4;

    localparam logic [6:0] SEG_OFF = 7'b1111111;

    // Active-low segment patterns a..g (MSB = a) for hex digits 0..F.
    localparam logic [6:0] GLYPHS [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0001100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

endpackage

// File: rtl/seg7_hex_decode.sv
// rtl/seg7_hex_decode.sv - combinational hex nibble to active-low glyph lookup
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [DIGIT_W-1:0] i_digit,
    output logic [6:0]         o_seg
);

    always_comb begin
        o_seg = GLYPHS[i_digit];
    end

endmodule

// File: rtl/seg7_mux_driver.sv
// rtl/seg7_mux_driver.sv - time-multiplexed common-anode digit scanner; SEG7_LZB_EN enables leading-zero blanking
module seg7_mux_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          en,
    input  logic                          load,
    input  logic [DIGIT_W*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]         dp_in,
    output logic [6:0]                    a_to_g,
    output logic                          dp,
    output logic [NUM_DIGITS-1:0]         an
);

    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [CNT_W-1:0]              r_cnt;
    logic [IDX_W-1:0]              r_idx;
    logic [DIGIT_W*NUM_DIGITS-1:0] r_value_q;
    logic [NUM_DIGITS-1:0]         r_dp_q;
    logic [NUM_DIGITS-1:0]         r_an;
    logic [6:0]                    r_seg;
    logic                          r_dp;

    logic [DIGIT_W*NUM_DIGITS-1:0] w_value_sh;
    logic [NUM_DIGITS-1:0]         w_dp_sh;
    logic [DIGIT_W-1:0]            w_digit;
    logic [6:0]                    w_glyph;
    logic                          w_dp_bit;
    logic                          w_tc;
    logic                          w_lzb;
    logic                          w_dark;

    // Selected digit sits in the low nibble after shifting; the upper bits
    // being zero is exactly the "this and all higher digits are 0" test.
    assign w_value_sh = r_value_q >> (DIGIT_W * int'(r_idx));
    assign w_dp_sh    = r_dp_q >> r_idx;
    assign w_digit    = w_value_sh[DIGIT_W-1:0];
    assign w_dp_bit   = w_dp_sh[0];
    assign w_tc       = (r_cnt == CNT_W'(REFRESH_DIV - 1));

`ifdef SEG7_LZB_EN
    assign w_lzb = (w_value_sh == '0) && (r_idx != '0) && !w_dp_bit;
`else
    assign w_lzb = 1'b0;
`endif

    assign w_dark = !en || (int'(r_cnt) < BLANK_CYCLES) || w_lzb;

    seg7_hex_decode u_decode (
        .i_digit (w_digit),
        .o_seg   (w_glyph)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt     <= '0;
            r_idx     <= '0;
            r_value_q <= '0;
            r_dp_q    <= '0;
            r_an      <= '1;
            r_seg     <= SEG_OFF;
            r_dp      <= 1'b1;
        end else begin
            if (load) begin
                r_value_q <= value;
                r_dp_q    <= dp_in;
            end

            if (w_tc) begin
                r_cnt <= '0;
                r_idx <= (r_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : r_idx + 1'b1;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end

            if (w_dark) begin
                r_an  <= '1;
                r_seg <= SEG_OFF;
                r_dp  <= 1'b1;
            end else begin
                r_an  <= ~(NUM_DIGITS'(1) << r_idx);
                r_seg <= w_glyph;
                r_dp  <= ~w_dp_bit;
            end
        end
    end

    assign an     = r_an;
    assign a_to_g = r_seg;
    assign dp     = r_dp;

endmodule

// File: tb/tb_seg7_mux_driver.sv
// tb/tb_seg7_mux_driver.sv - self-checking bench for seg7_mux_driver (honours SEG7_LZB_EN)
module tb_seg7_mux_driver;

    localparam int N = 4;
    localparam int R = 8;
    localparam int B = 2;

    logic          clk = 1'b0;
    logic          reset, en, load;
    logic [15:0]   value;
    logic [3:0]    dp_in;
    logic [6:0]    a_to_g;
    logic          dp;
    logic [3:0]    an;

    int checks   = 0;
    int failures = 0;

    // Reference state: edges elapsed since reset plus the captured value.
    int          m_t;
    logic [15:0] m_val;
    logic [3:0]  m_dp;
    logic [3:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp;

    logic [6:0] glyph_tab [16];

    typedef struct {
        logic [15:0] v;
        logic [3:0]  d;
        int          slot;
        logic [3:0]  an_x;
        logic [6:0]  seg_x;
        logic        dp_x;
    } vec_t;
    vec_t tbl [7];

    always #5 clk = ~clk;

    seg7_mux_driver #(
        .NUM_DIGITS   (N),
        .REFRESH_DIV  (R),
        .BLANK_CYCLES (B)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .en     (en),
        .load   (load),
        .value  (value),
        .dp_in  (dp_in),
        .a_to_g (a_to_g),
        .dp     (dp),
        .an     (an)
    );

    function automatic bit model_blanked(int slot);
`ifdef SEG7_LZB_EN
        if (slot == 0 || m_dp[slot]) return 1'b0;
        for (int j = slot; j < N; j++) begin
            if (((m_val / (16 ** j)) % 16) != 0) return 1'b0;
        end
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    task automatic compare(input string name, input logic [3:0] an_x,
                           input logic [6:0] seg_x, input logic dp_x);
        checks++;
        if (an !== an_x || a_to_g !== seg_x || dp !== dp_x) begin
            failures++;
            $display("FAIL %s t=%0d an=%b/%b a_to_g=%b/%b dp=%b/%b (actual/required)",
                     name, m_t, an, an_x, a_to_g, seg_x, dp, dp_x);
        end
    endtask

    task automatic step(input logic r, input logic e, input logic l,
                        input logic [15:0] v, input logic [3:0] d);
        int slot;
        int ph;
        reset = r; en = e; load = l; value = v; dp_in = d;
        @(posedge clk);
        e_an = 4'b1111; e_seg = 7'b1111111; e_dp = 1'b1;
        if (r) begin
            m_t = 0; m_val = '0; m_dp = '0;
        end else begin
            slot = (m_t / R) % N;
            ph   = m_t % R;
            if (e && ph >= B && !model_blanked(slot)) begin
                e_an  = ~(4'b0001 << slot);
                e_seg = glyph_tab[(m_val / (16 ** slot)) % 16];
                e_dp  = ~m_dp[slot];
            end
            if (l) begin m_val = v; m_dp = d; end
            m_t++;
        end
        #1;
        compare("model", e_an, e_seg, e_dp);
    endtask

    task automatic idle_until(input int t_target, input logic [15:0] v);
        while (m_t < t_target) step(1'b0, 1'b1, 1'b0, v, 4'h0);
    endtask

    initial begin
        glyph_tab = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                      7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                      7'b0000000, 7'b0001100, 7'b0001000, 7'b1100000,
                      7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
        tbl[0] = '{16'h12AF, 4'b0100, 0, 4'b1110, 7'b0111000, 1'b1};
        tbl[1] = '{16'h12AF, 4'b0100, 1, 4'b1101, 7'b0001000, 1'b1};
        tbl[2] = '{16'h12AF, 4'b0100, 2, 4'b1011, 7'b0010010, 1'b0};
        tbl[3] = '{16'h12AF, 4'b0100, 3, 4'b0111, 7'b1001111, 1'b1};
        tbl[4] = '{16'h0000, 4'b0000, 0, 4'b1110, 7'b0000001, 1'b1};
        tbl[5] = '{16'h8B3E, 4'b1000, 3, 4'b0111, 7'b0000000, 1'b0};
        tbl[6] = '{16'h7D64, 4'b0001, 1, 4'b1101, 7'b0100000, 1'b1};

        m_t = 0; m_val = '0; m_dp = '0;
        reset = 1'b1; en = 1'b1; load = 1'b0; value = '0; dp_in = '0;

        // Reset held 3 cycles, then 2 dark edges after release.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 1'b0, 16'h0, 4'h0);
            compare("reset_hold", 4'b1111, 7'b1111111, 1'b1);
        end
        for (int i = 0; i < B; i++) begin
            step(1'b0, 1'b1, 1'b0, 16'h0, 4'h0);
            compare("post_reset_dark", 4'b1111, 7'b1111111, 1'b1);
        end

        // Table: load right after reset, sample mid-way through the digit's lit window.
        foreach (tbl[k]) begin
            step(1'b1, 1'b1, 1'b0, 16'h0, 4'h0);
            step(1'b0, 1'b1, 1'b1, tbl[k].v, tbl[k].d);
            idle_until(tbl[k].slot * R + 5, 16'h0);
            compare($sformatf("table%0d", k), tbl[k].an_x, tbl[k].seg_x, tbl[k].dp_x);
        end

        // Frame repeat: digit 0 first lit at t=3, again 32 edges later.
        step(1'b1, 1'b1, 1'b0, 16'h0, 4'h0);
        step(1'b0, 1'b1, 1'b1, 16'h12AF, 4'b0100);
        idle_until(N * R + B + 1, 16'h0);
        compare("frame_repeat", 4'b1110, 7'b0111000, 1'b1);

        // Mid-slot load of 0 while digit 0 lit.
        step(1'b0, 1'b1, 1'b1, 16'h0000, 4'b0000);
        compare("midload_edge", 4'b1110, 7'b0111000, 1'b1);
        step(1'b0, 1'b1, 1'b0, 16'h0, 4'h0);
        compare("midload_next", 4'b1110, 7'b0000001, 1'b1);

        // en=0 for 10 cycles mid-frame; model tracks the position on resume.
        step(1'b0, 1'b1, 1'b1, 16'h4321, 4'b0000);
        idle_until(N * R + R + 4, 16'h0);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0, 1'b0, 16'h0, 4'h0);
            compare("en_off_dark", 4'b1111, 7'b1111111, 1'b1);
        end
        idle_until(3 * N * R, 16'h0);

        // Reset inside digit 2's slot, then scan restarts at digit 0.
        idle_until(3 * N * R + 2 * R + 4, 16'h0);
        step(1'b1, 1'b1, 1'b0, 16'h0, 4'h0);
        compare("reset_mid_frame", 4'b1111, 7'b1111111, 1'b1);
        idle_until(B + 1, 16'h0);
        compare("restart_digit0", 4'b1110, 7'b0000001, 1'b1);

        // Load and reset on the same edge: reset wins.
        step(1'b1, 1'b1, 1'b1, 16'hFFFF, 4'hF);
        idle_until(B + 2, 16'h0);
        compare("load_vs_reset", 4'b1110, 7'b0000001, 1'b1);

`ifdef SEG7_LZB_EN
        step(1'b1, 1'b1, 1'b0, 16'h0, 4'h0);
        step(1'b0, 1'b1, 1'b1, 16'h0005, 4'h0);
        idle_until(B + 2, 16'h0);
        compare("lzb_digit0", 4'b1110, 7'b0100100, 1'b1);
        idle_until(R + 4, 16'h0);
        compare("lzb_digit1_dark", 4'b1111, 7'b1111111, 1'b1);
        idle_until(2 * N * R, 16'h0);
`endif

        // Randomized run against the model.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 299) == 0),
                 ($urandom_range(0, 9) != 0),
                 ($urandom_range(0, 15) == 0),
                 16'($urandom_range(0, 3) == 0 ? $urandom_range(0, 255) : $urandom),
                 4'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
